// File: rtl/prog_delay_line_if.sv
// Sample-path bundle between the wrapper and the programmable delay line.
// Latency: none (wires only).
// Backpressure: none; the source stalls the stream through en.
interface prog_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 7
);
    logic             en;
    logic             clear;
    logic [WIDTH-1:0] din;
    logic             delay_load;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] delay_cur;
    logic             cfg_err;

    modport master (
        output en, clear, din, delay_load, delay_sel,
        input  dout, dout_valid, delay_cur, cfg_err
    );

    modport slave (
        input  en, clear, din, delay_load, delay_sel,
        output dout, dout_valid, delay_cur, cfg_err
    );
endinterface

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line over a circular buffer of MAX_DELAY samples.
// Latency: a sample accepted on enabled edge n is on dout after enabled edge n+D-1.
// Backpressure: en=0 freezes every register; clear/delay_load flush the fill tracking.
module prog_delay_line #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 90,
    parameter int DEFAULT_DELAY = 30,
    parameter int SEL_W         = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_delay_line_if.slave   dl
);
    localparam int               AW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(MAX_DELAY);
    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_DELAY);
    localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);
    localparam logic [AW-1:0]    LAST_PTR = AW'(MAX_DELAY - 1);
    localparam logic [31:0]      DEPTH_W  = 32'(MAX_DELAY);

    // Sample storage; never reset because dout is gated by dout_valid.
    logic [WIDTH-1:0] mem_q [MAX_DELAY];

    logic [AW-1:0]    wptr_q,  wptr_d;
    logic [SEL_W-1:0] fill_q,  fill_d;
    logic [SEL_W-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;

    logic [SEL_W-1:0] sel_clamped;
    logic             sel_bad;
    logic [SEL_W-1:0] d_eff;
    logic             accept;
    logic [SEL_W-1:0] fill_base;
    logic [SEL_W-1:0] fill_inc;
    logic [31:0]      ptr_w;
    logic [31:0]      back_w;
    logic [31:0]      rd_w;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] tap;

    // Clamp the requested delay into 1..MAX_DELAY and flag anything that needed clamping.
    always_comb begin
        sel_clamped = dl.delay_sel;
        sel_bad     = 1'b0;
        if (dl.delay_sel == '0) begin
            sel_clamped = ONE_SEL;
            sel_bad     = 1'b1;
        end else if (dl.delay_sel > MAX_SEL) begin
            sel_clamped = MAX_SEL;
            sel_bad     = 1'b1;
        end
    end

    // A load takes effect on its own edge, so the new delay governs that edge's output.
    assign d_eff     = dl.delay_load ? sel_clamped : delay_q;
    assign accept    = dl.en & ~dl.clear;
    assign fill_base = dl.delay_load ? '0 : fill_q;
    assign fill_inc  = (fill_base == MAX_SEL) ? fill_base : fill_base + ONE_SEL;

    // Read tap sits D-1 entries behind the write pointer, modulo the buffer depth.
    // The array is read combinationally before the edge writes it, so even when the
    // tap aliases the slot being overwritten the old contents are what get registered.
    always_comb begin
        ptr_w   = 32'(wptr_q);
        back_w  = 32'(d_eff) - 32'd1;
        rd_w    = (ptr_w >= back_w) ? (ptr_w - back_w) : (ptr_w + DEPTH_W - back_w);
        rd_addr = AW'(rd_w);
        tap     = (d_eff == ONE_SEL) ? dl.din : mem_q[rd_addr];
    end

    // Next-state: load/clear flush, then an accepted sample refills and produces output.
    always_comb begin
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (dl.delay_load) begin
            delay_d = sel_clamped;
            if (sel_bad) begin
                err_d = 1'b1;
            end
        end

        if (dl.clear || dl.delay_load) begin
            fill_d  = '0;
            valid_d = 1'b0;
            dout_d  = '0;
        end

        if (accept) begin
            wptr_d  = (wptr_q == LAST_PTR) ? '0 : wptr_q + AW'(1);
            fill_d  = fill_inc;
            valid_d = (fill_inc >= d_eff);
            dout_d  = (fill_inc >= d_eff) ? tap : '0;
        end
    end

    // Buffer write of each accepted sample at the write pointer.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wptr_q] <= dl.din;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            fill_q  <= '0;
            delay_q <= DEF_SEL;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            delay_q <= delay_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dl.dout       = dout_q;
    assign dl.dout_valid = valid_q;
    assign dl.delay_cur  = delay_q;
    assign dl.cfg_err    = err_q;
endmodule
